// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control strobes, memory word and decoded IR fields of the fetch unit
interface pc_fetch_unit_if;
  logic        pcwre;
  logic [1:0]  pcsrc;
  logic [31:0] imm32;
  logic [31:0] jraddr;
  logic        irwre;
  logic [31:0] insin;
  logic [31:0] iaddr;
  logic [31:0] pc4;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm16;
  logic        halted;
  logic        fault;
  modport slave (
    input  pcwre, pcsrc, imm32, jraddr, irwre, insin,
    output iaddr, pc4, ir, op, rs, rt, rd, sa, imm16, halted, fault
  );
  modport master (
    output pcwre, pcsrc, imm32, jraddr, irwre, insin,
    input  iaddr, pc4, ir, op, rs, rt, rd, sa, imm16, halted, fault
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction register with halt and illegal-PC detection
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128,
  parameter logic [5:0]  HALT_OP   = 6'b111111
) (
  input logic           clk,
  input logic           rst,
  pc_fetch_unit_if.slave bus
);
  typedef enum logic {RUN, HALT} state_t;
  localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);
  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, ir, ir_nx, pc4, target;
  logic        fault, fault_nx, legal;
  assign pc4    = pc + 32'd4;
  assign target = bus.pcsrc == 2'b00 ? pc4 :
                  bus.pcsrc == 2'b01 ? pc4 + (bus.imm32 << 2) :
                  bus.pcsrc == 2'b10 ? {pc4[31:28], ir[25:0], 2'b00} : bus.jraddr;
  assign legal  = target[1:0] == 2'b00 && target <= PC_MAX;
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    fault_nx = fault;
    if (state == RUN) begin
      if (bus.pcwre) begin
        pc_nx    = legal ? target : pc;
        fault_nx = fault | ~legal;
        state_nx = legal ? state_nx : HALT;
      end
      // the IR load proceeds even when the PC update faults on the same edge
      if (bus.irwre) begin
        ir_nx    = bus.insin;
        state_nx = bus.insin[31:26] == HALT_OP ? HALT : state_nx;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      ir    <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      fault <= fault_nx;
    end
  end
  assign bus.iaddr  = pc;
  assign bus.pc4    = pc4;
  assign bus.ir     = ir;
  assign bus.op     = ir[31:26];
  assign bus.rs     = ir[25:21];
  assign bus.rt     = ir[20:16];
  assign bus.rd     = ir[15:11];
  assign bus.sa     = ir[10:6];
  assign bus.imm16  = ir[15:0];
  assign bus.halted = state == HALT;
  assign bus.fault  = fault;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for the fetch unit with hand-computed expectations
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  pc_fetch_unit_if bus();
  pc_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.pcwre  = 1'b1;
    bus.irwre  = 1'b1;
    bus.pcsrc  = 2'b00;
    bus.imm32  = '0;
    bus.jraddr = '0;
    bus.insin  = 32'hDEAD_BEEF;
    step(2);
    chk("rst_pc", bus.iaddr, 32'h0);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_halted", {31'b0, bus.halted}, 32'h0);
    chk("rst_fault", {31'b0, bus.fault}, 32'h0);
    rst = 1'b1;
    bus.pcwre = 1'b0;
    bus.insin = 32'h0801_0008;
    step();
    chk("ld_ir", bus.ir, 32'h0801_0008);
    chk("ld_op", {26'b0, bus.op}, 32'h2);
    chk("ld_rt", {27'b0, bus.rt}, 32'h1);
    chk("ld_rs", {27'b0, bus.rs}, 32'h0);
    chk("ld_imm16", {16'b0, bus.imm16}, 32'h8);
    chk("ld_pc4", bus.pc4, 32'h4);
    bus.irwre = 1'b0;
    bus.pcwre = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq", bus.iaddr, 32'(i * 4));
    end
    step(4);
    chk("seq_1c", bus.iaddr, 32'h1C);
    bus.pcsrc = 2'b01;
    bus.imm32 = 32'hFFFF_FFFE;
    step();
    chk("branch", bus.iaddr, 32'h18);
    bus.pcsrc = 2'b00;
    bus.irwre = 1'b1;
    bus.insin = 32'hE000_0010;
    step(9);
    chk("pre_jump_pc", bus.iaddr, 32'h3C);
    chk("pre_jump_ir", bus.ir, 32'hE000_0010);
    bus.pcsrc = 2'b10;
    bus.insin = 32'h1234_5678;
    step();
    chk("jump_pc", bus.iaddr, 32'h40);
    chk("jump_ir", bus.ir, 32'h1234_5678);
    bus.irwre = 1'b0;
    bus.pcsrc = 2'b00;
    step(3);
    chk("pre_halt_pc", bus.iaddr, 32'h4C);
    bus.pcwre = 1'b0;
    bus.irwre = 1'b1;
    bus.insin = 32'hFC00_0000;
    step();
    chk("halt_flag", {31'b0, bus.halted}, 32'h1);
    chk("halt_ir", bus.ir, 32'hFC00_0000);
    chk("halt_nofault", {31'b0, bus.fault}, 32'h0);
    bus.pcwre = 1'b1;
    bus.insin = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_hold_pc", bus.iaddr, 32'h4C);
      chk("halt_hold_ir", bus.ir, 32'hFC00_0000);
    end
    rst = 1'b0;
    step();
    chk("halt_rst_pc", bus.iaddr, 32'h0);
    chk("halt_rst_halted", {31'b0, bus.halted}, 32'h0);
    rst = 1'b1;
    bus.irwre  = 1'b0;
    bus.pcsrc  = 2'b11;
    bus.jraddr = 32'h0000_007C;
    step();
    chk("jr_edge_pc", bus.iaddr, 32'h7C);
    chk("jr_edge_fault", {31'b0, bus.fault}, 32'h0);
    bus.jraddr = 32'h0000_0080;
    bus.irwre  = 1'b1;
    bus.insin  = 32'h0000_1111;
    step();
    chk("range_pc", bus.iaddr, 32'h7C);
    chk("range_fault", {31'b0, bus.fault}, 32'h1);
    chk("range_halted", {31'b0, bus.halted}, 32'h1);
    chk("range_ir", bus.ir, 32'h0000_1111);
    bus.insin = 32'h0000_2222;
    step();
    chk("fault_hold_ir", bus.ir, 32'h0000_1111);
    rst = 1'b0;
    step();
    chk("fault_rst", {31'b0, bus.fault}, 32'h0);
    rst = 1'b1;
    bus.irwre  = 1'b0;
    bus.jraddr = 32'h0000_0006;
    step();
    chk("align_pc", bus.iaddr, 32'h0);
    chk("align_fault", {31'b0, bus.fault}, 32'h1);
    chk("align_halted", {31'b0, bus.halted}, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
